// File: rtl/lockstep_cmp.sv
// -----------------------------------------------------------------------------
// lockstep_cmp
//
// Purpose:
//   Checker stage that sits right after the dual-core lockstep delay register.
//   Lane 0 of each OBI request bus carries the master core (already delayed by
//   NCYCLES), lane 1 carries the live shadow core. The two lanes are compared
//   every cycle once the pipelines have filled. A divergence raises a sticky
//   fault, bumps a saturating mismatch counter and, optionally, records
//   first-fault diagnostics for the safety controller.
//
// Configuration macro:
//   LOCKSTEP_CMP_CAPTURE_EN - when defined, builds the first-fault capture
//                             registers behind fault_chan_o / fault_addr_o.
//                             When undefined, both outputs are tied to zero.
//
// Parameters:
//   NCYCLES - lockstep delay of the upstream stage (ARM window length)
//   CNT_W   - width of the saturating mismatch counter
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   enable_i       in   lockstep mode enable (shared with the upstream stage)
//   clear_i        in   synchronous clear of fault, counter and capture
//   instr_req_i    in   aligned instruction requests, [0] master, [1] shadow
//   data_req_i     in   aligned data requests, same lane order
//   armed_o        out  high while comparisons are live (CHECK state)
//   fault_o        out  sticky divergence flag (FAULT state)
//   mismatch_cnt_o out  saturating count of mismatching cycles
//   fault_chan_o   out  first-fault channel: bit0 instr, bit1 data
//   fault_addr_o   out  lane-0 address at first fault
// -----------------------------------------------------------------------------

package lockstep_cmp_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

endpackage

module lockstep_cmp
    import lockstep_cmp_pkg::*;
#(
    parameter int unsigned NCYCLES = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  obi_req_t [1:0]       instr_req_i,
    input  obi_req_t [1:0]       data_req_i,
    output logic                 armed_o,
    output logic                 fault_o,
    output logic [CNT_W-1:0]     mismatch_cnt_o,
    output logic [1:0]           fault_chan_o,
    output logic [31:0]          fault_addr_o
);

    localparam int unsigned ARM_W = (NCYCLES < 1) ? 1 : $clog2(NCYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(NCYCLES);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARM      = 2'd1,
        ST_CHECK    = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic mm_instr;
    logic mm_data;
    logic mm;

    // Two lanes disagree if only one requests, or if both request and any
    // field that matters for that request differs. wdata only matters on
    // writes; an idle bus is never a mismatch regardless of stale fields.
    function automatic logic lane_mismatch(input obi_req_t m, input obi_req_t s);
        logic diff;
        diff = (m.req != s.req);
        if (m.req && s.req) begin
            if ((m.addr != s.addr) || (m.we != s.we) || (m.be != s.be)) begin
                diff = 1'b1;
            end
            if (m.we && s.we && (m.wdata != s.wdata)) begin
                diff = 1'b1;
            end
        end
        return diff;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mm_instr = lane_mismatch(instr_req_i[0], instr_req_i[1]);
    assign mm_data  = lane_mismatch(data_req_i[0], data_req_i[1]);
    assign mm       = mm_instr | mm_data;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_DISABLED;
            arm_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_DISABLED: begin
                if (enable_i) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = ARM_LOAD;
                end
            end

            ST_ARM: begin
                arm_cnt_d = arm_cnt_q - ARM_W'(1);
                if (!enable_i) begin
                    state_d = ST_DISABLED;
                end else if (arm_cnt_q == ARM_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                // Losing enable voids this cycle's comparison: the lanes are
                // no longer guaranteed to be aligned. A clear in the same
                // cycle likewise suppresses the fault.
                if (!enable_i) begin
                    state_d = ST_DISABLED;
                end else if (mm && !clear_i) begin
                    state_d = ST_FAULT;
                    cnt_d   = sat_inc(cnt_q);
                end
            end

            ST_FAULT: begin
                if (clear_i) begin
                    if (enable_i) begin
                        state_d   = ST_ARM;
                        arm_cnt_d = ARM_LOAD;
                    end else begin
                        state_d = ST_DISABLED;
                    end
                end else if (mm) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        // Clear beats any same-cycle increment.
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    // Outputs are pure state decodes, so they come straight off flops.
    always_comb begin
        armed_o = (state_q == ST_CHECK);
        fault_o = (state_q == ST_FAULT);
    end

    assign mismatch_cnt_o = cnt_q;

`ifdef LOCKSTEP_CMP_CAPTURE_EN
    logic        capture_evt;
    logic [1:0]  chan_q, chan_d;
    logic [31:0] addr_q, addr_d;

    // Same condition as the CHECK->FAULT transition above.
    assign capture_evt = (state_q == ST_CHECK) && enable_i && mm && !clear_i;

    always_comb begin
        chan_d = chan_q;
        addr_d = addr_q;
        if (clear_i) begin
            chan_d = '0;
            addr_d = '0;
        end else if (capture_evt) begin
            chan_d = {mm_data, mm_instr};
            addr_d = mm_data ? data_req_i[0].addr : instr_req_i[0].addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chan_q <= '0;
            addr_q <= '0;
        end else begin
            chan_q <= chan_d;
            addr_q <= addr_d;
        end
    end

    assign fault_chan_o = chan_q;
    assign fault_addr_o = addr_q;
`else
    assign fault_chan_o = '0;
    assign fault_addr_o = '0;
`endif

endmodule

// File: doc/lockstep_cmp.md
Name: lockstep_cmp

Overview:
- Checker stage directly downstream of the dual-core lockstep delay register.
- Consumes both lanes of the aligned instruction and data OBI request buses: lane 0 is the master core, already delayed by NCYCLES; lane 1 is the shadow core, live.
- Compares the two lanes cycle by cycle and raises a sticky fault on divergence.
- Counts mismatches and, optionally, captures first-fault diagnostics for the safety controller.

Parameters:
- NCYCLES, 2, lockstep delay of the upstream stage; sets the arming window length after enable.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- enable_i  in  1  lockstep mode enable; same signal that drives the upstream stage.
- clear_i  in  1  synchronous clear of fault, counter and capture registers.
- instr_req_i  in  obi_req_t[1:0]  aligned instruction requests; [0] master (delayed), [1] shadow.
- data_req_i  in  obi_req_t[1:0]  aligned data requests, same lane order.
- armed_o  out  1  high while in CHECK state.
- fault_o  out  1  sticky lockstep divergence flag.
- mismatch_cnt_o  out  CNT_W  saturating count of mismatching cycles.
- fault_chan_o  out  2  first-fault channel: bit0 instr, bit1 data.
- fault_addr_o  out  32  lane-0 address at first fault.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - State DISABLED.
  - armed_o=0, fault_o=0.
  - mismatch_cnt_o=0, fault_chan_o=0, fault_addr_o=0, arm counter=0.
- Per-channel mismatch (combinational, evaluated each cycle):
  - req differs → mismatch.
  - Both req=1 → additionally compare addr, we, be.
  - Both req=1 and we=1 → additionally compare wdata.
  - Both req=0 → never a mismatch, whatever the other fields hold.
  - mm = mm_instr | mm_data.
- FSM:
  - DISABLED:
    - enable_i=1 → ARM; arm counter loaded with NCYCLES.
    - No comparison in this state.
  - ARM:
    - Arm counter decrements each cycle; comparisons suppressed while pipelines fill.
    - Counter==1 and enable_i=1 → CHECK. Exactly NCYCLES cycles are spent in ARM.
    - enable_i=0 → DISABLED.
  - CHECK:
    - armed_o=1.
    - mm=1 → FAULT; counter +1; capture updated.
    - enable_i=0 → DISABLED. This takes priority over a same-cycle mm.
  - FAULT:
    - fault_o=1.
    - Counter keeps incrementing on each mm cycle.
    - Capture registers frozen.
    - enable_i=0 does not leave FAULT.
    - clear_i=1 → ARM if enable_i=1, else DISABLED.
- Latency:
  - fault_o rises on the edge ending the first mismatching CHECK cycle, i.e. registered, 1-cycle latency.
  - fault_o is a pure state decode and is glitch-free.
- Counter:
  - Saturates at 2^CNT_W-1; never wraps.
  - Counts only in CHECK or FAULT.
- clear_i:
  - In any state, clears counter and capture registers.
  - clear_i wins over a same-cycle mm: the counter becomes 0, not 1.
  - In DISABLED, CHECK and ARM, clear_i does not change state.
- enable_i dropped mid-ARM or mid-CHECK: state returns to DISABLED; counter is retained.
- Reset mid-operation: all state, outputs and counters return to reset values immediately.

Optional Feature:
- Macro: LOCKSTEP_CMP_CAPTURE_EN.
- Defined:
  - On the CHECK→FAULT transition, fault_chan_o={mm_data,mm_instr}.
  - fault_addr_o = data_req_i[0].addr if mm_data, else instr_req_i[0].addr.
  - Both registers hold until clear_i or reset.
- Undefined:
  - No capture flops are built.
  - fault_chan_o and fault_addr_o are tied to 0.
  - All other behaviour is identical.

Test Plan:
- Arming window:
  - Stimulus: NCYCLES=2, enable_i 0→1 at cycle 0, identical lanes.
  - Required: armed_o=0 in cycles 0–2 and 1 from cycle 3 onward; fault_o stays 0.
- Instr addr mismatch:
  - Stimulus: in CHECK, both instr req=1, addr 0x1000 vs 0x1004, for one cycle.
  - Required: next cycle fault_o=1 and mismatch_cnt_o=1; with the macro, fault_chan_o=2'b01 and fault_addr_o=0x1000.
- Ignored fields:
  - Stimulus: data req=0 on both lanes, addr/wdata differ; then req=1 with we=0 and wdata differing.
  - Required: no fault.
- Clear vs mismatch:
  - Stimulus: in FAULT with cnt=5, assert clear_i together with a mismatch, enable_i=1.
  - Required: next cycle cnt=0, fault_o=0, state ARM.
- Saturation and persistence:
  - Stimulus: CNT_W=2, 6 consecutive data wdata mismatches, then enable_i=0.
  - Required: cnt stops at 3; fault_o remains 1.
- Async reset:
  - Stimulus: rst_i pulse mid-CHECK, between clock edges.
  - Required: all outputs 0 immediately.
